// File: rtl/instr_mem_loader.sv
// Run-time programmable instruction store: byte-stream loader plus a combinational fetch port.
// Optional trailing checksum byte per session when INSTR_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; fetch-only
// LOAD  | accepting stream bytes into the assembly register
// WRITE | committing the assembled word to mem[addr]
// CSUM  | accepting the checksum byte (INSTR_LOADER_CHECKSUM_EN only)
// DONE  | one-cycle completion pulse
module instr_mem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       index,
    output logic [31:0]       InstrReg,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        CSUM  = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic [31:0]       mem [DEPTH];

    logic unused_index;
    assign unused_index = ^index[31:ADDR_W];

    // Upper index bits are dropped so fetches wrap modulo DEPTH.
    assign InstrReg = mem[index[ADDR_W-1:0]];

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len      <= '0;
            addr     <= '0;
            byte_cnt <= '0;
            asm_word <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
                        addr     <= '0;
                        byte_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        sum      <= '0;
                        err_q    <= 1'b0;
`endif
                        if (load_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            len      <= (load_len > DEPTH_W) ? DEPTH_W : load_len;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
                        // Shift-in gives big-endian order: first byte ends up in [31:24].
                        asm_word <= {asm_word[23:0], in_byte};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        sum      <= sum + in_byte;
`endif
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                WRITE: begin
                    mem[addr] <= asm_word;
                    if ({1'b0, addr} == len - LEN_ONE) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state    <= CSUM;
                        in_ready <= 1'b1;
`else
                        state    <= DONE;
                        done     <= 1'b1;
`endif
                    end else begin
                        addr     <= addr + ADR_ONE;
                        state    <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (in_valid && in_ready) begin
                        if (8'(sum + in_byte) != 8'h00) err_q <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= DONE;
                        done     <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
